// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with an 8-entry byte FIFO.
// Raw pins are synchronised, 11-bit frames are deframed and checked, and
// good bytes are buffered for the keyboard controller's pop handshake.
module ps2_rx_fifo #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Synchroniser chains: bit 0 is newest, bit 2 is oldest.
    logic [2:0]    clk_sync;
    logic [2:0]    data_sync;

    // Receiver state.
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [TW-1:0] tcnt;

    // FIFO state.
    logic [7:0]    mem [8];
    logic [2:0]    wptr;
    logic [2:0]    rptr;
    logic [3:0]    count;

    logic          fall;
    logic          bit_in;
    logic          frame_done;
    logic          frame_ok;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;

    // A falling edge is the oldest clock flop at 1 with the next one at 0;
    // the data bit is taken from the oldest data flop in the same cycle.
    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = data_sync[2];

    // The 11th edge carries the stop bit. shreg holds parity,d7..d0,start.
    assign frame_done = fall && (bit_cnt == 4'd10);
    assign frame_ok   = ~shreg[0] & bit_in & (^shreg[9:1]);

    assign full     = (count == 4'd8);
    assign pop      = ~nextdata_n & (count != 4'd0);
    assign push_req = frame_done & frame_ok;
    // When full, a simultaneous pop frees the slot the new byte needs.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    assign ready = (count != 4'd0);
    assign data  = mem[rptr];

    // Three-flop synchronisers on both raw pins, idling high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync  <= 3'b111;
            data_sync <= 3'b111;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[1:0], ps2_data};
        end
    end

    // Bit counter, shift register and stall timeout for frame reception.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt <= 4'd0;
            shreg   <= 10'd0;
            tcnt    <= '0;
        end else if (fall) begin
            tcnt <= '0;
            if (bit_cnt == 4'd10) begin
                bit_cnt <= 4'd0;
            end else begin
                shreg   <= {bit_in, shreg[9:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else if (bit_cnt != 4'd0) begin
            // A partial frame with no edges for too long is abandoned.
            if (tcnt == TW'(TIMEOUT_CYC)) begin
                bit_cnt <= 4'd0;
                shreg   <= 10'd0;
                tcnt    <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end else begin
            tcnt <= '0;
        end
    end

    // FIFO storage write; contents need no reset since ready gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= shreg[8:1];
        end
    end

    // FIFO pointers, occupancy, sticky overflow and the frame error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr      <= 3'd0;
            rptr      <= 3'd0;
            count     <= 4'd0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 3'd1;
            end
            if (pop) begin
                rptr <= rptr + 3'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (pop) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
            frame_err <= frame_done & ~frame_ok;
        end
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Testbench for ps2_rx_fifo: directed PS/2 frames with a byte scoreboard.
// Expected bytes and frame errors are queued by the stimulus; a monitor
// consumes them whenever the DUT pops a byte or pulses frame_err.
module tb_ps2_rx_fifo;

    localparam int TOUT = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];
    int         exp_err = 0;
    logic       fe_prev = 1'b0;
    logic [7:0] exp_b;

    ps2_rx_fifo #(.TIMEOUT_CYC(TOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // One PS/2 bit: data set up, clock low for 8 cycles, then high again.
    task automatic ps2_bit(input logic b);
        @(negedge clk); #1; ps2_data = b;
        repeat (4) @(negedge clk);
        #1; ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        #1; ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Sends frame bits lo..hi-1 of {stop, parity, d, start}.
    task automatic send_range(input logic [7:0] d, input logic pflip, input logic stp,
                              input int lo, input int hi);
        logic [10:0] fb;
        fb = {stp, (~^d) ^ pflip, d, 1'b0};
        for (int i = lo; i < hi; i++) ps2_bit(fb[i]);
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_range(d, 1'b0, 1'b1, 0, 11);
    endtask

    task automatic pop_one();
        @(negedge clk); #1; nextdata_n = 1'b0;
        @(negedge clk); #1; nextdata_n = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #1; rst = 1'b0;
        @(negedge clk); #1; rst = 1'b1;
    endtask

    // Monitor: sampled just before each rising edge, once inputs have settled.
    always @(negedge clk) begin
        #3;
        if (rst) begin
            if (!nextdata_n && ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_data: got %0h, expected no byte", data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (data !== exp_b) begin
                        errors++;
                        $display("FAIL pop_data: got %0h, expected %0h", data, exp_b);
                    end
                end
            end
            if (frame_err) begin
                checks++;
                if (fe_prev) begin
                    errors++;
                    $display("FAIL frame_err_width: got high 2 cycles, expected 1");
                end else if (exp_err == 0) begin
                    errors++;
                    $display("FAIL frame_err_unexpected: got 1, expected 0");
                end else begin
                    exp_err--;
                end
            end
        end
        fe_prev = frame_err;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        #1; rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame 0x1C with latency check on the stop-bit edge.
        exp_q.push_back(8'h1C);
        send_range(8'h1C, 1'b0, 1'b1, 0, 10);
        @(negedge clk); #1; ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        #1; ps2_clk = 1'b0;
        repeat (2) @(posedge clk);
        #1; chk("lat_before_E1", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1; chk("lat_ready_E1", {31'd0, ready}, 32'd1);
        chk("lat_data_E1", {24'd0, data}, 32'h1C);
        repeat (8) @(negedge clk);
        #1; ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        pop_one();
        chk("single_pop_ready", {31'd0, ready}, 32'd0);

        // Two-byte sequence.
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
        send_frame(8'hF0);
        send_frame(8'h1C);
        chk("seq_head", {24'd0, data}, 32'hF0);
        pop_one();
        chk("seq_second", {24'd0, data}, 32'h1C);
        pop_one();
        chk("seq_empty", {31'd0, ready}, 32'd0);

        // Bad parity, then bad stop bit.
        exp_err++;
        send_range(8'h1C, 1'b1, 1'b1, 0, 11);
        chk("bad_parity_ready", {31'd0, ready}, 32'd0);
        exp_err++;
        send_range(8'h1C, 1'b0, 1'b0, 0, 11);
        chk("bad_stop_ready", {31'd0, ready}, 32'd0);
        chk("bad_frames_seen", exp_err, 32'd0);

        // Overflow: nine bytes into eight slots, the ninth is lost.
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) exp_q.push_back(8'(i));
            send_frame(8'(i));
        end
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {28'd0, dut.count}, 32'd8);
        chk("ovf_head", {24'd0, data}, 32'h01);
        pop_one();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        chk("ovf_next", {24'd0, data}, 32'h02);
        for (int n = 0; n < 16 && ready; n++) pop_one();
        chk("ovf_drained", {31'd0, ready}, 32'd0);
        chk("ovf_queue_empty", exp_q.size(), 32'd0);

        // Stalled partial frame recovered by the timeout.
        send_range(8'hAA, 1'b0, 1'b1, 0, 5);
        repeat (TOUT + 10) @(negedge clk);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A);
        chk("timeout_data", {24'd0, data}, 32'h5A);
        chk("timeout_ready", {31'd0, ready}, 32'd1);
        pop_one();

        // Reset with bytes buffered and a frame in flight.
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        send_frame(8'h11);
        send_frame(8'h22);
        send_frame(8'h33);
        send_range(8'h44, 1'b0, 1'b1, 0, 4);
        pulse_reset();
        exp_q.delete();
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        send_range(8'h44, 1'b0, 1'b1, 4, 11);
        repeat (TOUT + 10) @(negedge clk);
        chk("rst_partial_ready", {31'd0, ready}, 32'd0);
        exp_q.push_back(8'h29);
        send_frame(8'h29);
        chk("rst_new_data", {24'd0, data}, 32'h29);
        pop_one();
        chk("rst_pop_ready", {31'd0, ready}, 32'd0);
        pop_one();
        chk("empty_pop_ready", {31'd0, ready}, 32'd0);
        chk("empty_pop_overflow", {31'd0, overflow}, 32'd0);

        repeat (5) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 32'd0);
        chk("final_frame_errs", exp_err, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
